// File: rtl/join_collector.sv
// join_collector: fork/join controller that launches child jobs and resumes the parent in all/any/none join modes.
// Optional WAIT-state timeout is enabled by defining JC_TIMEOUT_EN.
module join_collector #(
    parameter int N_CHILD        = 3,
    parameter int CNT_W          = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go_i,
    input  logic [1:0]         mode_i,
    input  logic [N_CHILD-1:0] child_en_i,
    input  logic [N_CHILD-1:0] child_done_i,
    output logic [N_CHILD-1:0] child_start_o,
    output logic               parent_resume_o,
    output logic               busy_o,
    output logic [N_CHILD-1:0] pending_o,
    output logic [N_CHILD-1:0] done_mask_o,
    output logic [CNT_W-1:0]   outstanding_o,
    output logic               error_o,
    output logic               timeout_o
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESUME} state_t;

    state_t             state, state_nx;
    logic [N_CHILD-1:0] launch_mask, pending, done_mask, acc, stray;
    logic [1:0]         mode;
    logic               error, accept, is_any, is_none, join_met, tmo_hit;

    if (2 ** CNT_W <= N_CHILD) begin : g_bad_cnt_w
        $error("CNT_W too narrow for N_CHILD");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** TMO_W) begin : g_bad_tmo_w
        $error("TIMEOUT_CYCLES does not fit TMO_W");
    end

    assign busy_o   = state != IDLE || |pending;
    assign accept   = go_i && !busy_o;
    assign acc      = child_done_i & pending;
    assign stray    = child_done_i & ~pending;
    assign is_any   = mode == 2'b01;
    assign is_none  = mode == 2'b10;
    assign join_met = is_any ? |acc : (pending & ~child_done_i) == '0;

`ifdef JC_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout;

    // counter reads i during the (i+1)th WAIT cycle, so the limit fires on the last allowed one
    assign tmo_hit   = state == WAIT && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1) && !join_met;
    assign timeout_o = timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= state == WAIT ? tmo_cnt + 1'b1 : '0;
            timeout <= accept ? 1'b0 : (timeout | tmo_hit);
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LAUNCH : IDLE;
            LAUNCH:  state_nx = (launch_mask == '0 || is_none) ? RESUME : WAIT;
            WAIT:    state_nx = (join_met || tmo_hit) ? RESUME : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // pending is empty while LAUNCH runs, so any done seen then lands in stray
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            launch_mask <= '0;
            mode        <= '0;
            pending     <= '0;
            done_mask   <= '0;
            error       <= 1'b0;
        end else begin
            pending <= state == LAUNCH ? launch_mask : pending & ~child_done_i;
            if (accept) begin
                launch_mask <= child_en_i;
                mode        <= mode_i;
                done_mask   <= '0;
                error       <= 1'b0;
            end else begin
                done_mask <= done_mask | acc;
                error     <= error | (|stray);
            end
        end
    end

    assign child_start_o   = state == LAUNCH ? launch_mask : '0;
    assign parent_resume_o = state == RESUME;
    assign pending_o       = pending;
    assign done_mask_o     = done_mask;
    assign error_o         = error;

    always_comb begin
        outstanding_o = '0;
        for (int i = 0; i < N_CHILD; i++) outstanding_o = outstanding_o + CNT_W'(pending[i]);
    end
endmodule

// File: tb/tb_join_collector.sv
// tb_join_collector: directed bench with a scoreboard of expected per-job results for join_collector.
// Timeout expectations follow JC_TIMEOUT_EN the same way the design does.
module tb_join_collector;
    logic       clk = 1'b0;
    logic       rst, go;
    logic [1:0] mode;
    logic [2:0] en, done;
    logic [2:0] child_start_o, pending_o, done_mask_o;
    logic       parent_resume_o, busy_o, error_o, timeout_o;
    logic [1:0] outstanding_o;

    typedef struct {
        int         res_k;
        int         res_n;
        int         res_out;
        logic [2:0] start0;
        logic [2:0] mask;
        logic [2:0] pend;
        int         busy_end;
        logic       err;
        logic       tmo;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, passes = 0;
    int         res_k, res_n, res_out, busy_end, extra;
    logic [2:0] start0, res_mask, res_pend;
    logic       res_tmo, err0, err_end;
    int         outs[0:63];

    join_collector #(.N_CHILD(3), .CNT_W(2), .TIMEOUT_CYCLES(20), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .go_i(go), .mode_i(mode), .child_en_i(en),
        .child_done_i(done), .child_start_o(child_start_o),
        .parent_resume_o(parent_resume_o), .busy_o(busy_o), .pending_o(pending_o),
        .done_mask_o(done_mask_o), .outstanding_o(outstanding_o),
        .error_o(error_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // k counts cycles from the start-pulse cycle (k=0); done/go are applied during cycle k
    task automatic run_job(input logic [1:0] m, input logic [2:0] e, input int d0, input int d1,
                           input int d2, input int go_at, input int ncyc);
        mode = m; en = e; go = 1'b1;
        tick();
        go = 1'b0;
        start0 = child_start_o; err0 = error_o;
        res_k = -1; res_n = 0; res_out = -1; res_mask = 'x; res_pend = 'x; res_tmo = 1'bx;
        busy_end = -1; extra = 0;
        for (int k = 0; k <= ncyc; k++) begin
            done = {d2 == k, d1 == k, d0 == k};
            go = k == go_at;
            outs[k] = outstanding_o;
            if (k > 0 && child_start_o != '0) extra++;
            if (parent_resume_o) begin
                if (res_n == 0) begin
                    res_k = k; res_out = outstanding_o; res_mask = done_mask_o;
                    res_pend = pending_o; res_tmo = timeout_o;
                end
                res_n++;
            end
            if (k > 0 && !busy_o && busy_end < 0) busy_end = k;
            tick();
        end
        done = '0; go = 1'b0;
        err_end = error_o;
    endtask

    task automatic score(input string name);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", name);
            return;
        end
        passes++;
        x = sb.pop_front();
        chk({name, "_start"}, start0, x.start0);
        chk({name, "_extra_start"}, extra, 0);
        chk({name, "_resume_k"}, res_k, x.res_k);
        chk({name, "_resume_n"}, res_n, x.res_n);
        chk({name, "_out_at_resume"}, res_out, x.res_out);
        chk({name, "_mask_at_resume"}, res_mask, x.mask);
        chk({name, "_pend_at_resume"}, res_pend, x.pend);
        chk({name, "_tmo_at_resume"}, res_tmo, x.tmo);
        chk({name, "_busy_end"}, busy_end, x.busy_end);
        chk({name, "_error"}, err_end, x.err);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; mode = '0; en = '0; done = '0;
        tick();
        chk("reset_outputs", {child_start_o, parent_resume_o, busy_o, pending_o, done_mask_o,
                              outstanding_o, error_o, timeout_o}, '0);
        tick();
        rst = 1'b0;
        tick();

        sb.push_back('{16, 1, 0, 3'b111, 3'b111, 3'b000, 17, 1'b0, 1'b0});
        run_job(2'b00, 3'b111, 5, 10, 15, -1, 40);
        score("all");
        chk("all_out_k1", outs[1], 3);
        chk("all_out_k6", outs[6], 2);
        chk("all_out_k11", outs[11], 1);
        chk("all_out_k16", outs[16], 0);

        sb.push_back('{6, 1, 2, 3'b111, 3'b001, 3'b110, 16, 1'b0, 1'b0});
        run_job(2'b01, 3'b111, 5, 10, 15, 8, 40);
        score("any");

        sb.push_back('{1, 1, 3, 3'b111, 3'b000, 3'b111, 16, 1'b0, 1'b0});
        run_job(2'b10, 3'b111, 5, 10, 15, -1, 40);
        score("none");

        sb.push_back('{1, 1, 0, 3'b000, 3'b000, 3'b000, 2, 1'b0, 1'b0});
        run_job(2'b00, 3'b000, -1, -1, -1, -1, 40);
        score("empty");

        sb.push_back('{4, 1, 0, 3'b011, 3'b011, 3'b000, 5, 1'b0, 1'b0});
        run_job(2'b00, 3'b011, 3, 3, -1, -1, 40);
        score("simul");

        sb.push_back('{5, 1, 0, 3'b011, 3'b011, 3'b000, 6, 1'b1, 1'b0});
        run_job(2'b00, 3'b011, 3, 4, 2, -1, 40);
        score("stray");

        sb.push_back('{3, 1, 0, 3'b001, 3'b001, 3'b000, 4, 1'b0, 1'b0});
        run_job(2'b11, 3'b001, 2, -1, -1, -1, 40);
        chk("err_cleared_by_go", err0, 1'b0);
        score("mode11");

        mode = 2'b00; en = 3'b111; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        done = 3'b001;
        tick();
        done = 3'b000;
        chk("rst_pre_outstanding", outstanding_o, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {child_start_o, parent_resume_o, busy_o, pending_o, done_mask_o,
                                  outstanding_o, error_o, timeout_o}, '0);
        tick();
        rst = 1'b0;
        tick();
        sb.push_back('{3, 1, 0, 3'b001, 3'b001, 3'b000, 4, 1'b0, 1'b0});
        run_job(2'b00, 3'b001, 2, -1, -1, -1, 40);
        score("after_rst");

`ifdef JC_TIMEOUT_EN
        sb.push_back('{21, 1, 1, 3'b001, 3'b000, 3'b001, 31, 1'b0, 1'b1});
`else
        sb.push_back('{31, 1, 0, 3'b001, 3'b001, 3'b000, 32, 1'b0, 1'b0});
`endif
        run_job(2'b00, 3'b001, 30, -1, -1, -1, 45);
        score("timeout");

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
